mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter.sv | 103 ++++++++++
 tb/tb_mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of data-port, fetch-port and single-port RAM signals around the arbiter.
// slave = arbiter side; master = requesters plus RAM.
interface mem_port_arbiter_if;
    logic        d_req;
    logic        d_we;
    logic [8:0]  d_addr;
    logic [15:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [15:0] d_rdata;

    logic        f_req;
    logic [8:0]  f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [15:0] f_rdata;

    logic [8:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata;

    logic [15:0] f_stall_cnt;

    modport slave (
        input  d_req, d_we, d_addr, d_wdata, f_req, f_addr, ram_rdata,
        output d_gnt, d_rvalid, d_rdata, f_gnt, f_rvalid, f_rdata,
        output ram_addr, ram_wdata, ram_we, f_stall_cnt
    );

    modport master (
        output d_req, d_we, d_addr, d_wdata, f_req, f_addr, ram_rdata,
        input  d_gnt, d_rvalid, d_rdata, f_gnt, f_rvalid, f_rdata,
        input  ram_addr, ram_wdata, ram_we, f_stall_cnt
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Data/fetch arbiter for one single-port sync-read RAM; combinational grant, read data 1 cycle later.
// No queueing: a denied requester holds its request; fetch is forced through after STARVE_LIMIT denials.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_D = 2'd1,
        RD_F = 2'd2
    } rd_state_t;

    rd_state_t   state_q, state_d;
    logic [2:0]  starve_q, starve_d;
    logic [15:0] stall_q, stall_d;
    logic        d_win, f_win, f_denied;

    // Grants are gated by rst so requests seen during reset never reach the RAM.
    always_comb begin
        d_win = 1'b0;
        f_win = 1'b0;
        if (rst) begin
            if (bus.f_req && (!bus.d_req || starve_q >= LIMIT)) begin
                f_win = 1'b1;
            end else if (bus.d_req) begin
                d_win = 1'b1;
            end
        end
        f_denied = bus.f_req && !f_win;
    end

    always_comb begin
        starve_d = '0;
        if (f_denied && starve_q != 3'd7) begin
            starve_d = starve_q + 3'd1;
        end else if (f_denied) begin
            starve_d = starve_q;
        end
        stall_d = stall_q + {15'd0, f_denied};
    end

    always_comb begin
        bus.d_gnt     = d_win;
        bus.f_gnt     = f_win;
        bus.ram_we    = d_win && bus.d_we;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (d_win) begin
            bus.ram_addr  = bus.d_addr;
            bus.ram_wdata = bus.d_wdata;
        end else if (f_win) begin
            bus.ram_addr  = bus.f_addr;
        end
        bus.f_stall_cnt = stall_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    // Writes complete in the grant cycle, so only granted reads open a return slot.
    always_comb begin
        state_d = IDLE;
        if (d_win && !bus.d_we) begin
            state_d = RD_D;
        end else if (f_win) begin
            state_d = RD_F;
        end
    end

    always_comb begin
        bus.d_rvalid = 1'b0;
        bus.d_rdata  = '0;
        bus.f_rvalid = 1'b0;
        bus.f_rdata  = '0;
        case (state_q)
            RD_D: begin
                bus.d_rvalid = 1'b1;
                bus.d_rdata  = bus.ram_rdata;
            end
            RD_F: begin
                bus.f_rvalid = 1'b1;
                bus.f_rdata  = bus.ram_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed check of mem_port_arbiter against a cycle-level reference model.
// A second instance with STARVE_LIMIT=7 is used only to reach the stall-counter wrap quickly.
module tb_mem_port_arbiter;

    localparam int LIMIT  = 3;
    localparam int LIMIT7 = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();
    mem_port_arbiter_if bus7 ();

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT7)) u_dut7 (
        .clk (clk),
        .rst (rst),
        .bus (bus7.slave)
    );

    // Single-port RAM with synchronous read.
    logic [15:0] ram [512] = '{default: 16'h0};
    always @(posedge clk) begin
        if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= ram[bus.ram_addr];
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [15:0] shadow [512] = '{default: 16'h0};
    int          m_starve = 0;
    int          m_stall  = 0;
    int          pend_kind = 0;
    logic [15:0] pend_data = '0;
    logic        m_last_d = 1'b0;
    logic        m_last_f = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_starve  = 0;
        m_stall   = 0;
        pend_kind = 0;
        pend_data = '0;
    endtask

    // Entered and left at posedge+1; outputs are sampled on the falling edge.
    task automatic step(input logic dr, input logic dwe, input logic [8:0] da,
                        input logic [15:0] dw, input logic fr, input logic [8:0] fa);
        logic exp_d, exp_f;
        bus.d_req   = dr;
        bus.d_we    = dwe;
        bus.d_addr  = da;
        bus.d_wdata = dw;
        bus.f_req   = fr;
        bus.f_addr  = fa;
        @(negedge clk);
        exp_f = fr && (!dr || m_starve >= LIMIT);
        exp_d = dr && !exp_f;
        chk("d_gnt", bus.d_gnt, exp_d);
        chk("f_gnt", bus.f_gnt, exp_f);
        chk("ram_we", bus.ram_we, exp_d && dwe);
        chk("ram_addr", bus.ram_addr, exp_d ? da : (exp_f ? fa : 9'd0));
        if (!exp_f) chk("ram_wdata", bus.ram_wdata, exp_d ? dw : 16'd0);
        chk("d_rvalid", bus.d_rvalid, pend_kind == 1);
        chk("d_rdata", bus.d_rdata, (pend_kind == 1) ? pend_data : 16'd0);
        chk("f_rvalid", bus.f_rvalid, pend_kind == 2);
        chk("f_rdata", bus.f_rdata, (pend_kind == 2) ? pend_data : 16'd0);
        chk("stall_cnt", bus.f_stall_cnt, m_stall);
        if (exp_d && !dwe) begin
            pend_kind = 1;
            pend_data = shadow[da];
        end else if (exp_f) begin
            pend_kind = 2;
            pend_data = shadow[fa];
        end else begin
            pend_kind = 0;
        end
        if (exp_d && dwe) shadow[da] = dw;
        if (fr && !exp_f) begin
            m_starve++;
            m_stall = (m_stall + 1) % 65536;
        end else begin
            m_starve = 0;
        end
        m_last_d = exp_d;
        m_last_f = exp_f;
        @(posedge clk);
        #1;
    endtask

    logic        rd_req, rd_we, rf_req;
    logic [8:0]  rd_a, rf_a;
    logic [15:0] rd_w;

    initial begin
        int s0;
        int s7, c7;
        bit seen, done;

        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 9'h5; bus.d_wdata = 16'hAAAA;
        bus.f_req = 1'b1; bus.f_addr = 9'h6;
        bus7.d_req = 1'b0; bus7.d_we = 1'b0; bus7.d_addr = '0; bus7.d_wdata = '0;
        bus7.f_req = 1'b0; bus7.f_addr = '0; bus7.ram_rdata = '0;

        // Requests during reset are ignored
        #12;
        chk("rst_d_gnt", bus.d_gnt, 0);
        chk("rst_f_gnt", bus.f_gnt, 0);
        chk("rst_ram_we", bus.ram_we, 0);
        chk("rst_d_rvalid", bus.d_rvalid, 0);
        chk("rst_f_rvalid", bus.f_rvalid, 0);
        chk("rst_stall", bus.f_stall_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();

        // Write, then read back; then the far-end write
        step(1, 1, 9'h012, 16'hBEEF, 0, 0);
        step(1, 0, 9'h012, 16'h0000, 0, 0);
        chk("r037_d_rvalid", bus.d_rvalid, 1);
        chk("r037_d_rdata", bus.d_rdata, 16'hBEEF);
        chk("r037_f_rvalid", bus.f_rvalid, 0);
        step(1, 1, 9'h1FF, 16'h1234, 0, 0);
        chk("r038_no_rvalid", bus.d_rvalid | bus.f_rvalid, 0);
        step(0, 0, 0, 0, 0, 0);

        // Both ports requesting continuously: D,D,D,F
        s0 = m_stall;
        for (int i = 0; i < 16; i++) step(1, 0, 9'h012, 16'h0, 1, 9'h1FF);
        chk("r039_stall", bus.f_stall_cnt, (s0 + 12) % 65536);
        step(0, 0, 0, 0, 0, 0);

        // Fetch-only stream alternating two addresses
        step(1, 1, 9'h000, 16'h0F0F, 0, 0);
        step(1, 1, 9'h001, 16'hF0F0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1, 9'(i % 2));
        chk("r040_f_rdata", bus.f_rdata, 16'hF0F0);

        // Random traffic; denied requests are held until granted
        rd_req = 0; rd_we = 0; rd_a = 0; rd_w = 0; rf_req = 0; rf_a = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!rd_req || m_last_d) begin
                rd_req = ($urandom_range(0, 99) < 60);
                rd_we  = ($urandom_range(0, 99) < 40);
                rd_a   = 9'($urandom_range(0, 15));
                rd_w   = 16'($urandom);
            end
            if (!rf_req || m_last_f) begin
                rf_req = ($urandom_range(0, 99) < 65);
                rf_a   = 9'($urandom_range(0, 15));
            end
            step(rd_req, rd_we, rd_a, rd_w, rf_req, rf_a);
        end

        // Reset mid-cycle right after a fetch grant
        step(0, 0, 0, 0, 1, 9'h001);
        chk("r041_pre_f_rvalid", bus.f_rvalid, 1);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.f_req = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk("r041_f_rvalid", bus.f_rvalid, 0);
        chk("r041_f_rdata", bus.f_rdata, 0);
        chk("r041_stall", bus.f_stall_cnt, 0);
        chk("r041_d_gnt", bus.d_gnt, 0);
        chk("r041_f_gnt", bus.f_gnt, 0);
        chk("r041_ram_we", bus.ram_we, 0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 9'h000);
        step(0, 0, 0, 0, 0, 0);

        // Stall counter wrap on the STARVE_LIMIT=7 instance
        bus7.d_req = 1'b1;
        bus7.f_req = 1'b1;
        s7 = 0; c7 = 0; seen = 0; done = 0;
        for (int i = 0; i < 80000 && !done; i++) begin
            bit deny;
            @(negedge clk);
            deny = (s7 < LIMIT7);
            if (i % 8192 == 0) begin
                chk("w_cnt", bus7.f_stall_cnt, c7);
                chk("w_f_gnt", bus7.f_gnt, !deny);
            end
            if (c7 == 16'hFFFF && !seen) begin
                chk("r042_ffff", bus7.f_stall_cnt, 16'hFFFF);
                seen = 1;
            end else if (seen && c7 == 0) begin
                chk("r042_wrap", bus7.f_stall_cnt, 16'h0000);
                done = 1;
            end
            if (deny) begin
                s7++;
                c7 = (c7 + 1) % 65536;
            end else begin
                s7 = 0;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("r042_timeout", 0, 1);
        bus7.d_req = 1'b0;
        bus7.f_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
